age_select_unit: RTL and testbench
==================================

// Module: age_select_unit
// PURPOSE
//  Multi-port, age-ordered select stage between issue-queue wakeup and the execution ports.
//  - Each cycle: grants up to ISSUE_WIDTH ready rows, oldest first, to the ports that can accept.
//  - Grants return to wakeup as a registered select_vector and to the ports as per-port valid/row.
//  - Successor of the single-vector request/select pairing: adds age ordering, multiple issue ports,
//    per-port backpressure, flush and a grant counter.
// PARAMETERS
//  NUM_ROWS     16                  issue-queue rows (request/select vector width), >=2
//  ISSUE_WIDTH  2                   issue ports granted per cycle, 1..NUM_ROWS
//  ROW_IDX_W    $clog2(NUM_ROWS)    row index width (derived, do not override)
//  CNT_W        32                  grant counter width
// PORTS
//  clk             in   1                       core clock
//  rst_n           in   1                       async active-low reset
//  flush           in   1                       sync flush: drop pending grants, reset age order
//  alloc_valid     in   1                       a row is (re)allocated this cycle
//  alloc_row       in   ROW_IDX_W               row being allocated; becomes youngest
//  request_vector  in   NUM_ROWS                rows woken and ready to issue
//  port_ready      in   ISSUE_WIDTH             port k can accept an instruction this cycle
//  select_valid    out  ISSUE_WIDTH             port k granted (registered)
//  select_row      out  ISSUE_WIDTH*ROW_IDX_W   granted row per port; slice k = [k*ROW_IDX_W +: ROW_IDX_W]
//  select_vector   out  NUM_ROWS                OR of the granted rows, one-hot per grant (registered)
//  grant_count     out  CNT_W                   total grants since reset/flush, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - select_valid=0, select_row=0, select_vector=0, grant_count=0.
//   - Age matrix: age[i][j]=1 iff i<j (lower index older).
//  Age matrix: NUM_ROWS x NUM_ROWS bits; age[i][j]=1 means row i older than row j.
//   - Diagonal unused.
//   - Invariant age[i][j] = ~age[j][i] for i!=j.
//   - On alloc_valid at the clock edge, for r=alloc_row and all j!=r: age[r][j]<=0, age[j][r]<=1.
//  Eligibility (combinational, same cycle):
//   - elig = request_vector & ~select_vector.
//   - The row granted last cycle is masked; wakeup must drop that request by the next cycle.
//   - If alloc_valid=1, bit alloc_row is also cleared from elig.
//  Selection:
//   - Ports are taken in order k=0..ISSUE_WIDTH-1.
//   - A port with port_ready[k]=0 takes no grant and consumes nothing.
//   - A ready port takes the oldest remaining eligible row: row i such that age[i][j]=1 for every
//     other remaining eligible j.
//   - That row is then removed from the remaining set.
//   - If no eligible row remains, the port gets no grant.
//   - Each row is granted at most once per cycle.
//   - Consequence: more ready rows than ready ports -> the youngest are left for later cycles.
//  Latency:
//   - Grants computed in cycle N appear on select_valid/select_row/select_vector in cycle N+1.
//   - Outputs are held for exactly 1 cycle, then recomputed. No output is held by backpressure.
//   - port_ready is sampled in the grant cycle.
//   - select_vector = OR over k of (select_valid[k] ? onehot(select_row[k]) : 0).
//   - For a port with select_valid[k]=0, select_row[k] is 0.
//  grant_count:
//   - Adds popcount(select_valid) each cycle.
//   - Saturates at 2^CNT_W-1; no wrap.
//  flush (sync, highest priority):
//   - Next cycle: all outputs 0, grant_count 0, age matrix back to its reset order.
//   - Requests and alloc in the flush cycle are ignored.
//  Simultaneous events:
//   - alloc plus grant of the same row in one cycle is impossible (masked above).
//   - alloc of a row granted last cycle is legal; the row becomes youngest.
//  Reset mid-operation: all state returns to reset values immediately. No partial grant is visible.
// TESTING
//  1. Reset; alloc rows 3,1,7 in that order; request=0x008A; port_ready=2'b11
//     -> next cycle select_row0=3, select_row1=1, select_vector=0x000A.
//     Following cycle, with request=0x0080 -> row 7 granted on port 0.
//  2. Age ties by index after reset: request=0xFFFF, port_ready=2'b11
//     -> grants rows 0,1. Next cycle (wakeup drops 0,1) -> rows 2,3.
//  3. Backpressure: request=0x0006, port_ready=2'b10
//     -> port0 no grant; port1 gets row 1; select_vector=0x0002.
//  4. Masking: request held at 0x0001 two cycles after a grant of row 0
//     -> no re-grant in the second cycle (select_valid=0).
//  5. Flush with request=0xFFFF
//     -> next cycle outputs 0, grant_count 0; next-next cycle grants rows 0,1.
//     Assert rst_n low mid-stream -> outputs 0 asynchronously.
//  6. Counter: force grant_count near max (CNT_W=4 build), grant 2/cycle
//     -> sticks at 15; no row granted to two ports (assertion every cycle).

Source files
------------

// File: rtl/age_select_unit.sv
// age_select_unit: age-ordered multi-port select between issue-queue wakeup and execution ports.
// Grants up to ISSUE_WIDTH ready rows per cycle, oldest first, with registered outputs.
module age_select_unit #(
  parameter int NUM_ROWS    = 16,
  parameter int ISSUE_WIDTH = 2,
  parameter int CNT_W       = 32,
  localparam int ROW_IDX_W  = $clog2(NUM_ROWS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             alloc_valid,
  input  logic [ROW_IDX_W-1:0]             alloc_row,
  input  logic [NUM_ROWS-1:0]              request_vector,
  input  logic [ISSUE_WIDTH-1:0]           port_ready,
  output logic [ISSUE_WIDTH-1:0]           select_valid,
  output logic [ISSUE_WIDTH*ROW_IDX_W-1:0] select_row,
  output logic [NUM_ROWS-1:0]              select_vector,
  output logic [CNT_W-1:0]                 grant_count
);
  localparam int PC_W = $clog2(ISSUE_WIDTH + 1);

  logic [NUM_ROWS-1:0]              age_q [NUM_ROWS];
  logic [NUM_ROWS-1:0]              age_d [NUM_ROWS];
  logic [ISSUE_WIDTH-1:0]           valid_q, valid_d;
  logic [ISSUE_WIDTH*ROW_IDX_W-1:0] row_q, row_d;
  logic [NUM_ROWS-1:0]              vec_q, vec_d, elig, rem, oldest;
  logic [ROW_IDX_W-1:0]             idx;
  logic [PC_W-1:0]                  pc;
  logic [CNT_W+PC_W-1:0]            sum;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;

  // A row is oldest when it is older than every other still-remaining eligible row.
  always_comb begin
    elig = request_vector & ~vec_q;
    if (alloc_valid) elig[alloc_row] = 1'b0;
    rem     = elig;
    valid_d = '0;
    row_d   = '0;
    vec_d   = '0;
    oldest  = '0;
    idx     = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      for (int i = 0; i < NUM_ROWS; i++)
        oldest[i] = rem[i] & (&(age_q[i] | ~rem | (NUM_ROWS'(1) << i)));
      idx = '0;
      for (int i = 0; i < NUM_ROWS; i++)
        if (oldest[i]) idx = ROW_IDX_W'(i);
      if (port_ready[k] && |oldest) begin
        valid_d[k]                         = 1'b1;
        row_d[k*ROW_IDX_W +: ROW_IDX_W]    = idx;
        vec_d                              = vec_d | oldest;
        rem                                = rem & ~oldest;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ROWS; i++)
      for (int j = 0; j < NUM_ROWS; j++)
        age_d[i][j] = flush ? 1'(i < j) : age_q[i][j];
    if (alloc_valid && !flush)
      for (int j = 0; j < NUM_ROWS; j++)
        if (ROW_IDX_W'(j) != alloc_row) begin
          age_d[alloc_row][j] = 1'b0;
          age_d[j][alloc_row] = 1'b1;
        end
  end

  always_comb begin
    pc = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) pc = pc + PC_W'(valid_q[k]);
    sum   = {{PC_W{1'b0}}, cnt_q} + (CNT_W+PC_W)'(pc);
    cnt_d = flush ? '0 : (|sum[CNT_W+PC_W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      row_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_ROWS; i++)
        for (int j = 0; j < NUM_ROWS; j++)
          age_q[i][j] <= 1'(i < j);
    end else begin
      valid_q <= flush ? '0 : valid_d;
      row_q   <= flush ? '0 : row_d;
      vec_q   <= flush ? '0 : vec_d;
      cnt_q   <= cnt_d;
      age_q   <= age_d;
    end
  end

  assign select_valid  = valid_q;
  assign select_row    = row_q;
  assign select_vector = vec_q;
  assign grant_count   = cnt_q;
endmodule

// File: tb/tb_age_select_unit.sv
// tb_age_select_unit: random and directed stimulus against a timestamp-ordered reference model.
// A CNT_W=4 copy shares the inputs to exercise counter saturation.
module tb_age_select_unit;
  localparam int N = 16;
  localparam int IW = 2;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, alloc_valid;
  logic [W-1:0]  alloc_row;
  logic [N-1:0]  request_vector;
  logic [IW-1:0] port_ready;
  logic [IW-1:0] select_valid, select_valid4;
  logic [IW*W-1:0] select_row, select_row4;
  logic [N-1:0]  select_vector, select_vector4;
  logic [31:0]   grant_count;
  logic [3:0]    grant_count4;

  age_select_unit #(.NUM_ROWS(N), .ISSUE_WIDTH(IW), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_valid(alloc_valid), .alloc_row(alloc_row),
    .request_vector(request_vector), .port_ready(port_ready), .select_valid(select_valid),
    .select_row(select_row), .select_vector(select_vector), .grant_count(grant_count));

  age_select_unit #(.NUM_ROWS(N), .ISSUE_WIDTH(IW), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .alloc_valid(alloc_valid), .alloc_row(alloc_row),
    .request_vector(request_vector), .port_ready(port_ready), .select_valid(select_valid4),
    .select_row(select_row4), .select_vector(select_vector4), .grant_count(grant_count4));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic chk = 1'b0;

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: each row carries an allocation timestamp; smaller stamp means older.
  int            stamp [N];
  int            tnext;
  logic [IW-1:0] e_valid;
  logic [W-1:0]  e_row [IW];
  logic [N-1:0]  e_vec, el, nv;
  logic [31:0]   e_cnt;
  int            e_cnt4, pc, best;
  longint        s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < N; i++) stamp[i] = i;
      tnext = N;
      e_valid = '0;
      e_vec = '0;
      for (int k = 0; k < IW; k++) e_row[k] = '0;
      e_cnt = '0;
      e_cnt4 = 0;
    end else begin
      pc = $countones(e_valid);
      s = longint'(e_cnt) + pc;
      e_cnt = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
      e_cnt4 = (e_cnt4 + pc > 15) ? 15 : e_cnt4 + pc;
      el = request_vector & ~e_vec;
      if (alloc_valid) el[alloc_row] = 1'b0;
      nv = '0;
      e_valid = '0;
      for (int k = 0; k < IW; k++) begin
        e_row[k] = '0;
        if (port_ready[k]) begin
          best = -1;
          for (int i = 0; i < N; i++)
            if (el[i] && (best < 0 || stamp[i] < stamp[best])) best = i;
          if (best >= 0) begin
            e_valid[k] = 1'b1;
            e_row[k] = W'(best);
            el[best] = 1'b0;
            nv[best] = 1'b1;
          end
        end
      end
      e_vec = nv;
      if (alloc_valid) begin
        stamp[alloc_row] = tnext;
        tnext++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk && rst_n) begin
      check("valid", select_valid, e_valid);
      for (int k = 0; k < IW; k++) check("row", select_row[k*W +: W], e_row[k]);
      check("vector", select_vector, e_vec);
      check("count", grant_count, e_cnt);
      check("valid4", select_valid4, e_valid);
      check("count4", grant_count4, e_cnt4);
      check("dup_grant", (select_valid == 2'b11) && (select_row[3:0] == select_row[7:4]), 0);
    end
  end

  task automatic drive(input logic f, input logic av, input logic [W-1:0] ar,
                       input logic [N-1:0] rq, input logic [IW-1:0] rd);
    flush = f;
    alloc_valid = av;
    alloc_row = ar;
    request_vector = rq;
    port_ready = rd;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    alloc_valid = 1'b0;
    alloc_row = '0;
    request_vector = '0;
    port_ready = '0;
    #1;
    check("reset_valid", select_valid, 0);
    check("reset_vector", select_vector, 0);
    check("reset_count", grant_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk = 1'b1;
    drive(0, 1, 3, 0, 2'b11);
    drive(0, 1, 1, 0, 2'b11);
    drive(0, 1, 7, 0, 2'b11);
    drive(0, 0, 0, 16'h008A, 2'b11);
    check("t1_row0", select_row[3:0], 3);
    check("t1_row1", select_row[7:4], 1);
    check("t1_vec", select_vector, 16'h000A);
    drive(0, 0, 0, 16'h0080, 2'b11);
    check("t1_valid_b", select_valid, 2'b01);
    check("t1_row0_b", select_row[3:0], 7);
    chk = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", select_valid, 0);
    check("async_row", select_row, 0);
    check("async_vec", select_vector, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk = 1'b1;
    drive(0, 0, 0, 16'hFFFF, 2'b11);
    check("t2_rows_a", {select_row[7:4], select_row[3:0]}, 8'h10);
    drive(0, 0, 0, 16'hFFFC, 2'b11);
    check("t2_rows_b", {select_row[7:4], select_row[3:0]}, 8'h32);
    drive(0, 0, 0, 0, 2'b11);
    drive(0, 0, 0, 16'h0006, 2'b10);
    check("t3_valid", select_valid, 2'b10);
    check("t3_row", select_row, 8'h10);
    check("t3_vec", select_vector, 16'h0002);
    drive(0, 0, 0, 0, 2'b11);
    drive(0, 0, 0, 16'h0001, 2'b11);
    check("t4_grant", select_valid, 2'b01);
    drive(0, 0, 0, 16'h0001, 2'b11);
    check("t4_masked", select_valid, 2'b00);
    drive(0, 1, 1, 16'hFFFF, 2'b11);
    check("t5_pre_rows", {select_row[7:4], select_row[3:0]}, 8'h20);
    drive(1, 1, 0, 16'hFFFF, 2'b11);
    check("t5_flush_valid", select_valid, 0);
    check("t5_flush_count", grant_count, 0);
    drive(0, 0, 0, 16'hFFFF, 2'b11);
    check("t5_post_rows", {select_row[7:4], select_row[3:0]}, 8'h10);
    repeat (12) drive(0, 0, 0, 16'hFFFF, 2'b11);
    check("t6_sat4", grant_count4, 15);
    repeat (3000)
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, W'($urandom),
            N'($urandom), IW'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
